icache_controller: RTL
======================

Name: icache_controller

Overview:
- Direct-mapped instruction cache controller between the IF stage and the block-based instruction memory (128-bit block read, 6-bit block address, READ/BUSYWAIT handshake).
- Serves 32-bit instructions to the pipeline in zero extra cycles on a hit.
- On a miss, stalls IF, sequences a block refill from instruction memory, then replays the lookup.
- Provides a FLUSH input that invalidates the whole cache, used for fence.i and program reload.

Parameters:
- MEM_ADDR_W, 6: block address width of instruction memory; covers 1 KiB in 16-byte blocks.
- INDEX_W, 3: line index width, giving 8 lines.
- TAG_W is a localparam equal to MEM_ADDR_W - INDEX_W (3). It is not overridable.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PC  in  32  fetch byte address. Bits [1:0] are ignored; bits [31:10] are ignored (aliased).
- PC_VALID  in  1  fetch request this cycle.
- FLUSH  in  1  invalidate all lines (single-cycle pulse or level).
- INSTRUCTION  out  32  fetched instruction.
- BUSYWAIT  out  1  stall to the pipeline.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  MEM_ADDR_W  block address = PC[9:4] of the missing fetch.
- MEM_READDATA  in  128  block from memory; byte n occupies bits [8n+7:8n].
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Address split:
  - word offset = PC[3:2]
  - index = PC[6:4]
  - tag = PC[9:7]
  - word w of a line is MEM_READDATA[32w+31:32w].
- Storage: 8 lines, each holding valid (1), tag (3) and data (128). Only the controller writes it.
- Reset (RESET_N low, asynchronous):
  - state = IDLE; all valid bits cleared.
  - MEM_READ = 0, MEM_ADDRESS = 0.
  - BUSYWAIT = 0, INSTRUCTION = NOP (32'h00000013).
  - Tag and data contents are don't-care.
  - Reset asserted mid-refill aborts immediately; MEM_READ drops asynchronously.
- State IDLE:
  - hit = PC_VALID & valid[index] & (tag[index] == PC tag). This is combinational.
  - On a hit: INSTRUCTION = selected word and BUSYWAIT = 0 in the same cycle (zero-latency hit).
  - On a miss (PC_VALID & !hit): BUSYWAIT = 1 combinationally and INSTRUCTION = NOP. At the next edge, latch MEM_ADDRESS = PC[9:4] and go to MEM_REQ.
  - When PC_VALID = 0: BUSYWAIT = 0 and INSTRUCTION = NOP.
- State MEM_REQ:
  - MEM_READ = 1 and BUSYWAIT = 1; MEM_ADDRESS is held stable.
  - The first cycle in MEM_REQ is the issue cycle. MEM_BUSYWAIT is ignored there, so a memory whose BUSYWAIT lags READ is tolerated.
  - On any later edge with MEM_BUSYWAIT = 0: capture MEM_READDATA into the line register and go to UPDATE.
  - There is no timeout; the controller waits indefinitely.
- State UPDATE (exactly 1 cycle):
  - MEM_READ = 0, BUSYWAIT = 1.
  - At the edge, write data[index], tag[index] and valid[index] = 1, using the index and tag from the latched MEM_ADDRESS.
  - Go to IDLE, where the current PC is looked up again and now hits.
- Miss penalty: 1 (IDLE detect) + 1 (issue) + k (memory busy cycles after issue) + 1 (UPDATE). BUSYWAIT is continuous throughout.
- PC changes during a refill (branch redirect):
  - The refill completes for the latched address.
  - IDLE then evaluates the new PC; this may miss again.
  - No request is ever aborted mid-handshake.
- FLUSH:
  - At any edge where FLUSH = 1, all valid bits are cleared.
  - If this happens in MEM_REQ, the refill still completes the handshake, but UPDATE writes the line with valid = 0.
  - The discard is tracked by a sticky flush_pending bit, cleared on entry to IDLE.
  - FLUSH in IDLE coincident with a hit: that cycle's instruction is still delivered; the next cycle misses.
- Simultaneous FLUSH and the UPDATE edge: the line is written invalid.
- BUSYWAIT never depends on MEM_READDATA; there is no combinational path from memory data to stall.

Decomposition:
- Package icache_pkg holds:
  - state enum {IDLE, MEM_REQ, UPDATE}
  - NOP_INSTR = 32'h00000013
  - field widths (word offset 2, index 3, tag 3, block 128)
  - a function that selects a 32-bit word from a 128-bit block.
- One natural sub-module, icache_line_array: 8-entry valid/tag/data storage.
  - Asynchronous clear of valid bits, plus flush clear.
  - Single synchronous write port and combinational read port.
  - Implemented as flops; the FSM and handshake stay in icache_controller.

Test Plan:
- Reset, then PC = 0x000 with PC_VALID: BUSYWAIT goes high the same cycle. MEM_READ rises next edge with MEM_ADDRESS = 0. Memory model busy for 5 cycles returns a block with words {W3,W2,W1,W0}. BUSYWAIT falls after UPDATE and INSTRUCTION = W0. Total stall = 8 cycles.
- After that fill, PC = 0x004, 0x008, 0x00C on consecutive cycles: INSTRUCTION = W1, W2, W3 with BUSYWAIT = 0 and MEM_READ = 0 throughout.
- Conflict miss: fill PC = 0x010 (index 1, tag 0), then PC = 0x090 (index 1, tag 1). The second access misses with MEM_ADDRESS = 6'h09. Returning to 0x010 misses again (line evicted).
- FLUSH pulsed mid-MEM_REQ for PC = 0x020: the handshake completes and BUSYWAIT drops into IDLE. The same PC misses again and issues a second refill to MEM_ADDRESS = 6'h02. The second fill then hits.
- PC redirected from 0x040 to 0x100 during the refill of 0x040: the first refill completes to address 6'h04. The controller then immediately issues a refill to 6'h10, and INSTRUCTION equals the word from the 0x100 block.
- RESET_N asserted for one cycle mid-refill: MEM_READ and BUSYWAIT drop asynchronously. After release, previously filled PC = 0x000 misses (valid cleared).

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache controller:
// FSM state encoding, field widths, the NOP instruction returned whenever no
// valid instruction is available, and a helper that extracts one 32-bit word
// from a 128-bit cache block.
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int WORD_W       = 32;
  localparam int BLOCK_W      = 128;
  localparam int WORD_OFF_W   = 2;   // word offset within a block, PC[3:2]
  localparam int LINE_INDEX_W = 3;   // default line index width, PC[6:4]
  localparam int LINE_TAG_W   = 3;   // default tag width, PC[9:7]

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  // Word w of a block lives in bits [32w+31:32w].
  function automatic logic [WORD_W-1:0] select_word(
    input logic [BLOCK_W-1:0]    block,
    input logic [WORD_OFF_W-1:0] offset
  );
    return block[{offset, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
// Bundles the fetch-side (pipeline) and refill-side (instruction memory)
// signals of the instruction cache.
//   pc, pc_valid, flush        : fetch request and invalidate from the pipeline
//   instruction, busywait      : fetched word and stall back to the pipeline
//   mem_read, mem_address      : block read request to instruction memory
//   mem_readdata, mem_busywait : block data and busy flag from memory
// Modports:
//   slave  - the cache controller
//   master - the environment (pipeline + instruction memory)
// -----------------------------------------------------------------------------
interface icache_if #(
  parameter int MEM_ADDR_W = 6
);

  logic [31:0]           pc;
  logic                  pc_valid;
  logic                  flush;
  logic [31:0]           instruction;
  logic                  busywait;
  logic                  mem_read;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [127:0]          mem_readdata;
  logic                  mem_busywait;

  modport slave (
    input  pc, pc_valid, flush, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );

  modport master (
    output pc, pc_valid, flush, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );

endinterface

// File: rtl/icache_line_array.sv
// -----------------------------------------------------------------------------
// icache_line_array
// Line storage for the direct-mapped instruction cache: 2**INDEX_W entries of
// {valid, tag, 128-bit data}, built from flops.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (clears valid bits)
//   flush          : clears every valid bit at the edge; wins over a write
//   wr_en          : write enable for the single synchronous write port
//   wr_index       : line being written
//   wr_tag/wr_data : tag and block stored into the line
//   wr_valid       : valid bit stored into the line
//   rd_index       : combinational read address
//   rd_valid/rd_tag/rd_data : contents of line rd_index
// -----------------------------------------------------------------------------
module icache_line_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = LINE_INDEX_W,
  parameter int TAG_W   = LINE_TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  // A flush on the same edge as a refill write leaves that line invalid.
  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= wr_valid;
    end
  end

  // NOTE: tag and data are only ever consumed when qualified by valid, so they
  // carry no reset; this keeps the wide storage off the reset tree.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_controller.sv
// -----------------------------------------------------------------------------
// icache_controller
// Direct-mapped instruction cache between the IF stage and a block-based
// instruction memory. Hits return the instruction in the same cycle; a miss
// stalls IF, refills the whole 128-bit block, then replays the lookup.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset (clears all valid bits, aborts refill)
//   bus   : icache_if.slave - fetch request/response and memory handshake
// PC decode: offset PC[3:2], index PC[4 +: INDEX_W], tag above the index,
// block address PC[4 +: MEM_ADDR_W]; PC[1:0] and the upper bits are ignored.
// -----------------------------------------------------------------------------
module icache_controller
  import icache_pkg::*;
#(
  parameter int MEM_ADDR_W = 6,
  parameter int INDEX_W    = LINE_INDEX_W
) (
  input  logic    clk,
  input  logic    rst_n,
  icache_if.slave bus
);

  localparam int TAG_W   = MEM_ADDR_W - INDEX_W;
  localparam int BLK_LSB = WORD_OFF_W + 2;  // first PC bit above the byte offset

  state_t                state_q, state_d;
  logic [MEM_ADDR_W-1:0] mem_address_q;
  logic                  issue_done_q;     // past the first MEM_REQ cycle
  logic                  flush_pending_q;  // refill in flight must be discarded
  logic [BLOCK_W-1:0]    line_q;           // block captured from memory

  logic [WORD_OFF_W-1:0] pc_offset;
  logic [INDEX_W-1:0]    pc_index;
  logic [TAG_W-1:0]      pc_tag;
  logic [MEM_ADDR_W-1:0] pc_block;
  logic                  unused_pc_bits;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [BLOCK_W-1:0]    rd_data;
  logic                  hit;
  logic                  miss;
  logic                  capture;

  assign pc_offset      = bus.pc[WORD_OFF_W+1:2];
  assign pc_index       = bus.pc[BLK_LSB +: INDEX_W];
  assign pc_tag         = bus.pc[BLK_LSB+INDEX_W +: TAG_W];
  assign pc_block       = bus.pc[BLK_LSB +: MEM_ADDR_W];
  assign unused_pc_bits = ^{bus.pc[31:BLK_LSB+MEM_ADDR_W], bus.pc[1:0]};

  icache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush),
    .wr_en    (state_q == UPDATE),
    .wr_index (mem_address_q[INDEX_W-1:0]),
    .wr_tag   (mem_address_q[MEM_ADDR_W-1:INDEX_W]),
    .wr_valid (!flush_pending_q),
    .wr_data  (line_q),
    .rd_index (pc_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit  = bus.pc_valid && rd_valid && (rd_tag == pc_tag);
  assign miss = bus.pc_valid && !hit;

  // Memory busy is ignored in the issue cycle so a memory whose busy flag
  // lags the read request cannot be mistaken for an immediate response.
  assign capture = (state_q == MEM_REQ) && issue_done_q && !bus.mem_busywait;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss)    state_d = MEM_REQ;
      MEM_REQ: if (capture) state_d = UPDATE;
      UPDATE:               state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // NOTE: every output gets a default before the case so no path through the
  // block leaves a signal unassigned, which would infer a latch.
  always_comb begin
    bus.instruction = NOP_INSTR;
    bus.busywait    = 1'b0;
    bus.mem_read    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          bus.instruction = select_word(rd_data, pc_offset);
        end else if (miss) begin
          bus.busywait = 1'b1;
        end
      end
      MEM_REQ: begin
        bus.busywait = 1'b1;
        bus.mem_read = 1'b1;
      end
      UPDATE: begin
        bus.busywait = 1'b1;
      end
      default: ;
    endcase
    // The pipeline sees an idle, non-stalling cache while reset is held,
    // even though a fetch request may still be presented.
    if (!rst_n) begin
      bus.instruction = NOP_INSTR;
      bus.busywait    = 1'b0;
    end
  end

  assign bus.mem_address = mem_address_q;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address_q   <= '0;
      issue_done_q    <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      issue_done_q <= (state_q == MEM_REQ);
      if (state_q == IDLE && miss) begin
        mem_address_q <= pc_block;
      end
      // A flush at the miss-detect edge predates the refill, so only flushes
      // seen while the request is outstanding poison the incoming block.
      unique case (state_q)
        IDLE:    flush_pending_q <= 1'b0;
        MEM_REQ: flush_pending_q <= flush_pending_q | bus.flush;
        default: flush_pending_q <= flush_pending_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      line_q <= bus.mem_readdata;
    end
  end

endmodule
